// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage: WIDTH-bit payload, valid/ready handshake, two-entry
// skid buffer (main M drives the output, skid S absorbs one beat of back-pressure).
module pipe_stage_reg #(
  parameter int unsigned      WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic             m_vld_q, m_vld_d;
  logic             s_vld_q, s_vld_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic [WIDTH-1:0] s_data_q, s_data_d;
  logic             in_fire, out_fire;

  // in_ready depends on registered state and reset only, never on out_ready.
  assign in_ready  = ~s_vld_q & reset_n;
  assign out_valid = m_vld_q;
  assign out_data  = m_vld_q ? m_data_q : BUBBLE;
  assign count     = {m_vld_q & s_vld_q, m_vld_q ^ s_vld_q};

  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_vld_q & out_ready;

  always_comb begin
    m_vld_d  = m_vld_q;
    s_vld_d  = s_vld_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    if (flush) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (!m_vld_q) begin
      if (in_fire) begin
        m_vld_d  = 1'b1;
        m_data_d = in_data;
      end
    end else if (out_fire) begin
      if (s_vld_q) begin
        m_data_d = s_data_q;
        s_vld_d  = 1'b0;
      end else if (in_fire) begin
        m_data_d = in_data;
      end else begin
        m_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      s_vld_d  = 1'b1;
      s_data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
    end else begin
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
    end
  end

  // Payload registers carry no reset; out_data masks them with BUBBLE when empty.
  always_ff @(posedge clk) begin
    m_data_q <= m_data_d;
    s_data_q <= s_data_d;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline stage register that generalises the fixed-width, enable-only inter-stage latches of the CPU pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a WIDTH-bit payload with a valid/ready handshake and a two-entry skid buffer, so back-pressure never drops or duplicates data. A synchronous flush turns the stage into a bubble carrying a configurable NOP payload. Instances sit between any two pipeline stages; stall is expressed by deasserting out_ready downstream.

## Interface
- WIDTH, 32: payload width in bits, ≥1.
- BUBBLE, {WIDTH{1'b0}}: payload presented on out_data whenever out_valid=0 (e.g. 32'h0000_0000 NOP for an instruction field).

- clk  input  1  rising-edge clock; the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of stage contents, high-active.
- in_valid  input  1  upstream holds valid payload.
- in_ready  output  1  stage can accept payload this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  stage presents valid payload.
- out_ready  input  1  downstream accepts payload this cycle.
- out_data  output  WIDTH  presented payload; BUBBLE when out_valid=0.
- count  output  2  occupancy, 0..2.

## Operation
- Storage: main register (M, drives out_data) and skid register (S), each with a valid bit.
- Accept: in_fire = in_valid & in_ready. Release: out_fire = out_valid & out_ready.
- in_ready = ~S.valid & reset_n (registered state only, no combinational path from out_ready).
- out_valid = M.valid; out_data = M.valid ? M.data : BUBBLE.
- count = M.valid + S.valid.
- Next state when flush=0:
  - M empty, in_fire: M←in_data.
  - M full, out_fire, S empty, in_fire: M←in_data.
  - M full, out_fire, S empty, no in_fire: M empties.
  - M full, no out_fire, in_fire: S←in_data (S was empty since in_ready=1).
  - M full, out_fire, S full: M←S, S empties (no in_fire possible).
  - M full, no out_fire, S full: hold all.
- Ordering: strict FIFO; S is never presented ahead of M.
- flush=1: M.valid and S.valid clear at the edge, regardless of in_fire/out_fire in that cycle; payload accepted in a flush cycle is discarded. The upstream handshake still completes (in_ready unaffected in that cycle); an out_fire during the flush cycle counts as delivered.
- Data registers load only when the corresponding valid is written; stale data is never visible because out_data is muxed to BUBBLE.
- Reset (reset_n low, async): M.valid=S.valid=0 immediately; out_valid=0, out_data=BUBBLE, count=0, in_ready=0. Data registers need not be reset.

## Timing
- Latency: input accepted at edge N appears on out_data/out_valid after edge N (visible in cycle N+1).
- Throughput: one transfer per cycle with out_ready held high; S stays empty.
- Back-pressure: first cycle of out_ready=0 with M full still accepts one beat into S; in_ready drops the cycle after S fills.
- Recovery: after out_ready returns high with S full, M←S at that edge, in_ready high the following cycle; no bubble inserted if upstream is valid.
- Flush: out_valid=0, count=0, in_ready=1 the cycle after the flush edge.
- reset_n release: in_ready=1 in the first cycle with reset_n high; first accept on the next rising edge.
- Reset asserted mid-transfer: contents lost, outputs go to reset values without waiting for clk.

## Test plan
- Streaming: out_ready=1, in_valid=1 with data 1,2,3,…,10 on consecutive cycles -> out_data 1..10 on consecutive cycles, one cycle delayed, count ≤1, in_ready stays 1.
- Stall: fill with A, hold out_ready=0, offer B then C -> B lands in S, count=2, in_ready=0, C held upstream; raise out_ready -> A, B, C delivered in order, no loss or duplicate.
- Flush: count=2 (A,B), assert flush one cycle with in_valid=1, in_data=C -> next cycle out_valid=0, out_data=BUBBLE, count=0, in_ready=1; C never emitted.
- Bubble value: WIDTH=32, BUBBLE=32'h0000_0013, empty stage -> out_data=32'h0000_0013; after accepting 32'hDEAD_BEEF and draining -> returns to 32'h0000_0013.
- Async reset: count=2, drop reset_n between clock edges -> out_valid, count, in_ready go to 0 without a clk edge; release -> in_ready=1 the next cycle, first accepted beat appears one cycle later.
- Random: random in_valid/out_ready/flush (flush ≈5%), WIDTH=8 -> output sequence matches a reference queue cleared on flush; count always equals queue length ≤2.
